// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multi-cycle RV32 core: walks FETCH/DECODE/EXEC/MEM/WB,
// gates datapath write enables, shares one memory port and traps on faults.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             branch,
  input  logic             unknown_op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             alu_out_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tcnt_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             trap_set, retire, in_req, timeout_hit;

  assign in_req      = (state_q == ST_FETCH) || (state_q == ST_MEM);
  // Counter holds the number of wait cycles already spent; this cycle would be wait TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_START;
      tcnt_q    <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (trap_set) cause_q <= cause_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (in_req && !mem_ready && (TIMEOUT != 0)) tcnt_q <= tcnt_q + TW'(1);
      else tcnt_q <= '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = 2'b00;
    trap_set   = 1'b0;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    alu_out_we = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d  = ST_TRAP;
          trap_set = 1'b1;
          cause_d  = 2'b10;
        end
      end
      ST_DECODE: begin
        if (unknown_op) begin
          state_d  = ST_TRAP;
          trap_set = 1'b1;
          cause_d  = 2'b01;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_out_we = 1'b1;
        if (branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (mem_read || mem_write) begin
          state_d = ST_MEM;
        end else if (reg_write) begin
          state_d = ST_WB;
        end else begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = mem_write;
        if (mem_ready) begin
          if (mem_read) begin
            mdr_we  = 1'b1;
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (timeout_hit) begin
          state_d  = ST_TRAP;
          trap_set = 1'b1;
          cause_d  = 2'b10;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: halted = 1'b1;
      default: begin
        state_d  = ST_TRAP;
        trap_set = 1'b1;
        cause_d  = 2'b01;
      end
    endcase
  end

  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level reference model driving
// randomized instruction streams, with per-cycle comparison of every output.
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 8;
  localparam int K_ALU = 0, K_NOP = 1, K_BR = 2, K_LD = 3, K_ST = 4, K_UNK = 5;
  localparam logic [9:0] S_REQ = 10'h200, S_WE = 10'h100, S_ADDR = 10'h080, S_IR = 10'h040,
                         S_ALU = 10'h020, S_MDR = 10'h010, S_RF = 10'h008, S_PCWE = 10'h004,
                         S_PCSEL = 10'h002, S_HALT = 10'h001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, branch = 1'b0, unknown_op = 1'b0;
  logic branch_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_we, alu_out_we, mdr_we, rf_we, pc_we, pc_sel, halted;
  logic [1:0]    trap_cause;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .branch(branch), .unknown_op(unknown_op),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .alu_out_we(alu_out_we),
    .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted),
    .trap_cause(trap_cause), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [22:0] act_vec;
  assign act_vec = {mem_req, mem_we, addr_sel, ir_we, alu_out_we, mdr_we, rf_we, pc_we,
                    pc_sel, halted, trap_cause, state, instret};

  int            tests = 0;
  int            fails = 0;
  string         exp_name = "idle";
  logic [22:0]   exp_vec = '0;
  bit            exp_valid = 1'b0;
  logic [CW-1:0] instret_m = '0;
  logic [1:0]    cause_m = 2'b00;
  int            ncyc = 0;
  bit            tr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (exp_valid) chk(exp_name, 32'(act_vec), 32'(exp_vec));

  task automatic rand_inputs();
    {mem_read, mem_write, reg_write, branch, unknown_op} = 5'($urandom);
    mem_ready    = 1'($urandom);
    branch_taken = 1'($urandom);
  endtask

  task automatic set_dec(input int kind);
    {mem_read, mem_write, reg_write, branch, unknown_op} = 5'b0;
    case (kind)
      K_ALU: reg_write = 1'b1;
      K_BR:  begin {mem_read, mem_write, reg_write} = 3'($urandom); branch = 1'b1; end
      K_LD:  begin mem_read = 1'b1; reg_write = 1'($urandom); end
      K_ST:  begin mem_write = 1'b1; reg_write = 1'($urandom); end
      K_UNK: begin {mem_read, mem_write, reg_write, branch} = 4'($urandom); unknown_op = 1'b1; end
      default: ;
    endcase
  endtask

  // One clock cycle of the model: publish the expectation, then let the edge happen.
  task automatic cyc(input string nm, input logic [2:0] st, input logic [9:0] stb, input bit ret);
    exp_name  = nm;
    exp_vec   = {stb, cause_m, st, instret_m};
    exp_valid = 1'b1;
    ncyc++;
    @(posedge clk); #1;
    if (ret) instret_m = instret_m + 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_inputs();
    exp_name  = "in_reset";
    exp_vec   = '0;
    exp_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    instret_m = '0;
    cause_m   = 2'b00;
    rand_inputs();
    cyc("start", 3'd0, 10'h0, 1'b0);
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      mem_ready = 1'(i);
      cyc("trap_hold", 3'd7, S_HALT, 1'b0);
    end
  endtask

  // One instruction: wf/wm = wait cycles before mem_ready in FETCH/MEM, ab = MEM cycle to abort by reset.
  task automatic run_instr(input int kind, input int wf, input int wm, input int bt,
                           input int ab, output bit trapped);
    trapped = 1'b0;
    ncyc    = 0;
    for (int i = 0; i < 64; i++) begin
      rand_inputs();
      mem_ready = (i == wf);
      if (mem_ready) begin
        cyc("fetch", 3'd1, S_REQ | S_IR, 1'b0);
        break;
      end
      cyc("fetch_wait", 3'd1, S_REQ, 1'b0);
      if (i == TO - 1) begin cause_m = 2'b10; trapped = 1'b1; return; end
    end
    rand_inputs();
    set_dec(kind);
    cyc("decode", 3'd2, 10'h0, 1'b0);
    if (kind == K_UNK) begin cause_m = 2'b01; trapped = 1'b1; return; end
    mem_ready    = 1'($urandom);
    branch_taken = 1'(bt);
    if (kind == K_BR) begin
      cyc("exec_branch", 3'd3, S_ALU | S_PCWE | (bt != 0 ? S_PCSEL : 10'h0), 1'b1);
      return;
    end
    if (kind == K_NOP) begin
      cyc("exec_nop", 3'd3, S_ALU | S_PCWE, 1'b1);
      return;
    end
    cyc("exec", 3'd3, S_ALU, 1'b0);
    if (kind == K_LD || kind == K_ST) begin
      for (int i = 0; i < 64; i++) begin
        mem_ready    = (i == wm);
        branch_taken = 1'($urandom);
        if (i == ab) begin
          exp_valid = 1'b0;
          rst_n = 1'b0;
          #2;
          chk("async_reset_outputs", 32'(act_vec), 32'h0);
          return;
        end
        if (mem_ready) begin
          if (kind == K_LD) begin
            cyc("mem_load", 3'd4, S_REQ | S_ADDR | S_MDR, 1'b0);
            break;
          end
          cyc("mem_store", 3'd4, S_REQ | S_ADDR | S_WE | S_PCWE, 1'b1);
          return;
        end
        cyc("mem_wait", 3'd4, S_REQ | S_ADDR | (kind == K_ST ? S_WE : 10'h0), 1'b0);
        if (i == TO - 1) begin cause_m = 2'b10; trapped = 1'b1; return; end
      end
    end
    rand_inputs();
    cyc("wb", 3'd5, S_RF | S_PCWE, 1'b1);
  endtask

  function automatic int pick_wait(input bit allow_trap);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 50) return 0;
    if (r < 75) return 1;
    if (r < 85) return 2;
    if (r < 95 || !allow_trap) return 3;
    return 4 + int'($urandom_range(0, 2));
  endfunction

  initial begin
    #2;
    do_reset();
    // Zero-wait R-type: 0,1,2,3,5 then FETCH
    run_instr(K_ALU, 0, 0, 0, -1, tr);
    chk("rtype_cycles", ncyc, 4);
    chk("rtype_instret", 32'(instret), 1);
    chk("rtype_next_state", 32'(state), 1);
    run_instr(K_BR, 0, 0, 1, -1, tr);
    chk("branch_taken_cycles", ncyc, 3);
    run_instr(K_BR, 0, 0, 0, -1, tr);
    chk("branch_not_taken_cycles", ncyc, 3);
    chk("branch_instret", 32'(instret), 3);
    run_instr(K_LD, 0, 2, 0, -1, tr);
    chk("load_2wait_cycles", ncyc, 7);
    run_instr(K_ST, 0, 0, 0, -1, tr);
    chk("store_cycles", ncyc, 4);
    chk("after_store_instret", 32'(instret), 5);
    run_instr(K_NOP, 0, 0, 0, -1, tr);
    // Fetch timeout with mem_ready stuck low
    run_instr(K_ALU, 9, 0, 0, -1, tr);
    chk("timeout_trapped", 32'(tr), 1);
    chk("timeout_cycles", ncyc, 4);
    trap_hold(5);
    chk("timeout_cause", 32'(trap_cause), 2);
    chk("timeout_halted", 32'(halted), 1);
    do_reset();
    run_instr(K_ALU, 3, 0, 0, -1, tr);
    chk("ready_on_last_cycle_no_trap", 32'(tr), 0);
    chk("ready_on_last_cycle_cycles", ncyc, 7);
    // Illegal opcode
    run_instr(K_UNK, 0, 0, 0, -1, tr);
    chk("illegal_cycles", ncyc, 2);
    trap_hold(20);
    chk("illegal_cause", 32'(trap_cause), 1);
    chk("illegal_instret_frozen", 32'(instret), 1);
    // Reset during a store's MEM wait
    do_reset();
    run_instr(K_ALU, 0, 0, 0, -1, tr);
    run_instr(K_ST, 0, 5, 0, 1, tr);
    do_reset();
    run_instr(K_ALU, 0, 0, 0, -1, tr);
    chk("post_abort_instret", 32'(instret), 1);
    // Long trap-free stream exercises instret wrap
    for (int k = 0; k < 300; k++)
      run_instr(int'($urandom_range(0, 4)), pick_wait(1'b0), pick_wait(1'b0),
                int'($urandom_range(0, 1)), -1, tr);
    for (int k = 0; k < 200; k++) begin
      run_instr(($urandom_range(0, 19) == 0) ? K_UNK : int'($urandom_range(0, 4)),
                pick_wait(1'b1), pick_wait(1'b1), int'($urandom_range(0, 1)), -1, tr);
      if (tr) begin
        trap_hold(int'($urandom_range(2, 6)));
        do_reset();
      end
    end
    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
